keccak_padder: RTL and testbench
================================

KECCAK_PADDER -- requirements
Module: keccak_padder

Interface
REQ-001 SHALL provide clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL provide reset, input, 1, synchronous active-high reset.
REQ-003 SHALL provide in, input, 32, message word; first byte in in[31:24].
REQ-004 SHALL provide in_ready, input, 1, in/is_last/byte_num valid this cycle.
REQ-005 SHALL provide is_last, input, 1, current word ends the message.
REQ-006 SHALL provide byte_num, input, 2, valid bytes (0-3) in the word when is_last=1, MSB-first.
REQ-007 SHALL provide buffer_full, output, 1, word not accepted this cycle (backpressure).
REQ-008 SHALL provide out, output, 576, assembled rate block; first word at out[575:544].
REQ-009 SHALL provide out_ready, output, 1, out holds a complete block for the permutation.
REQ-010 SHALL provide f_ack, input, 1, permutation has absorbed out (one-cycle pulse).

Function
REQ-011 SHALL accept a word iff in_ready=1, buffer_full=0 and state=ACCEPT; shift it into out from the LSB end, then increment word counter cnt (0..18).
REQ-012 SHALL use states ACCEPT, PAD, FULL, DONE.
REQ-013 SHALL take ACCEPT->FULL when cnt reaches 18 with no message end; buffer_full=out_ready=1 the next cycle.
REQ-014 SHALL, on accepted is_last word, store byte_num valid bytes, then PAD_FIRST at byte position byte_num, then zero bytes.
REQ-015 SHALL, after is_last, enter PAD and insert one zero word per cycle until cnt=18, then OR 0x80 into out[7:0] and enter FULL.
REQ-016 SHALL, if is_last word with byte_num=3 is word 18, produce out[7:0]=PAD_FIRST|0x80 in that block.
REQ-017 SHALL, if a full block completes with no is_last, accept the following is_last word as word 1 of the next block.
REQ-018 SHALL, on f_ack in FULL, clear cnt, deassert out_ready and buffer_full next cycle, and return to ACCEPT or, if the block was padded, DONE.
REQ-019 SHALL ignore f_ack outside FULL and accept no word in the f_ack cycle.
REQ-020 SHALL hold buffer_full=1 in PAD, FULL and DONE; DONE is left only by reset.
REQ-021 SHALL give latency of one cycle from the 18th word accept (or final PAD cycle) to out_ready=1.
REQ-022 SHALL hold out stable while out_ready=1.

Reset
REQ-023 SHALL on reset set state=ACCEPT, cnt=0, out=0, out_ready=0, buffer_full=0, overriding any concurrent in_ready or f_ack.
REQ-024 SHALL discard any partial or padded block on reset mid-operation.

Configuration
REQ-025 SHALL select PAD_FIRST=0x01 (original Keccak) when KECCAK_LEGACY_PAD_EN is defined.
REQ-026 SHALL select PAD_FIRST=0x06 (FIPS-202 SHA3 domain suffix) when KECCAK_LEGACY_PAD_EN is undefined.

Structure
REQ-027 SHALL place RATE_BITS=576, WORDS_PER_BLOCK=18, PAD_LAST=0x80, PAD_FIRST and the state enum in shared package keccak_pkg.
REQ-028 SHALL implement last-word byte masking and PAD_FIRST insertion in one combinational sub-module, pad_word (in, byte_num -> 32-bit word).

Verification
REQ-029 SHALL cover empty message: one word, is_last=1, byte_num=0 -> out=0x06 followed by 70 zero bytes and 0x80; out_ready after 18 cycles.
REQ-030 SHALL cover "abc": in=0x61626300, is_last=1, byte_num=3 -> out[575:544]=0x61626306, out[7:0]=0x80.
REQ-031 SHALL cover 17 full words then is_last byte_num=3 -> out[31:0]={3 data bytes,0x86}; legacy build gives 0x81.
REQ-032 SHALL cover 18 full words then is_last byte_num=0 -> block 1 unpadded; after f_ack, block 2 = 0x06, zeros, 0x80; then DONE with buffer_full=1.
REQ-033 SHALL cover in_ready held during FULL with f_ack delayed 5 cycles -> no word accepted, out unchanged, word accepted in the cycle after f_ack.
REQ-034 SHALL cover reset in PAD after 5 words -> cnt=0, out=0, out_ready=0 next cycle; new message then processes normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak rate-block padder.
// Define KECCAK_LEGACY_PAD_EN to select the original Keccak pad byte instead of the SHA3 suffix.
package keccak_pkg;

  localparam int RATE_BITS       = 576;
  localparam int WORDS_PER_BLOCK = 18;
  localparam int CNT_W           = 5;

  localparam logic [7:0] PAD_LAST = 8'h80;

`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] PAD_FIRST = 8'h01;
`else
  localparam logic [7:0] PAD_FIRST = 8'h06;
`endif

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    FULL   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/keccak_padder_pad_word.sv
// Final-word formatter: keeps the first byte_num bytes (MSB-first), writes PAD_FIRST
// at position byte_num and zeroes the remaining bytes.
module pad_word
  import keccak_pkg::*;
(
  input  logic [31:0] in,
  input  logic [1:0]  byte_num,
  output logic [31:0] out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    // Byte gi = 0 is the first message byte, living in in[31:24].
    localparam logic [1:0] POS = 2'(gi);
    assign out[31-8*gi -: 8] = (POS < byte_num)  ? in[31-8*gi -: 8] :
                               (POS == byte_num) ? PAD_FIRST : 8'h00;
  end

endmodule

// File: rtl/keccak_padder.sv
// Collects 32-bit message words into a 576-bit rate block and applies Keccak padding.
// Pad byte selection is controlled by KECCAK_LEGACY_PAD_EN (see keccak_pkg).
module keccak_padder
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [1:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RATE_BITS-1:0] out_q, out_d;
  logic                 padded_q, padded_d;

  logic [31:0]          last_word;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 last_slot;
  logic                 accept;

  pad_word u_pad_word (
    .in       (in),
    .byte_num (byte_num),
    .out      (last_word)
  );

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_slot = (cnt_inc == CNT_W'(WORDS_PER_BLOCK));
  assign accept    = in_ready && !buffer_full && (state_q == ACCEPT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCEPT;
      cnt_q    <= '0;
      out_q    <= '0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      padded_q <= padded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    padded_d = padded_q;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          out_d    = {out_q[RATE_BITS-33:0], (is_last ? last_word : in)};
          cnt_d    = cnt_inc;
          padded_d = is_last;
          if (last_slot) begin
            // A final word landing in slot 18 also carries the closing pad bit.
            if (is_last) out_d[7:0] = out_d[7:0] | PAD_LAST;
            state_d = FULL;
          end else if (is_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        out_d = {out_q[RATE_BITS-33:0], 32'h0000_0000};
        cnt_d = cnt_inc;
        if (last_slot) begin
          out_d[7:0] = PAD_LAST;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (f_ack) begin
          cnt_d   = '0;
          state_d = padded_q ? DONE : ACCEPT;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    buffer_full = (state_q != ACCEPT);
    out_ready   = (state_q == FULL);
  end

  assign out = out_q;

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder: empty, short, boundary and
// multi-block messages, backpressure during FULL, and reset in the middle of padding.
module tb_keccak_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_w;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out_w;
  logic         out_ready;
  logic         f_ack;

  int checks = 0;
  int errors = 0;

`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] PF = 8'h01;
`else
  localparam logic [7:0] PF = 8'h06;
`endif

  logic [575:0] exp_blk;
  logic [575:0] pad_only_blk;
  logic [31:0]  w;

  always #5 clk = ~clk;

  keccak_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out_w),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  task automatic chk_blk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] word, input logic last, input logic [1:0] bn);
    in_w     = word;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    is_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_ack();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
  endtask

  // Counts clock edges until out_ready rises, bounded so a stuck design still reaches the summary.
  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!out_ready && n < 64) begin
      step();
      n++;
    end
    chk_w(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    pad_only_blk          = '0;
    pad_only_blk[575:568] = PF;
    pad_only_blk[7:0]     = 8'h80;

    // Reset overrides concurrent in_ready and f_ack.
    reset = 1'b1; in_ready = 1'b1; f_ack = 1'b1; in_w = 32'hFFFF_FFFF;
    is_last = 1'b1; byte_num = 2'd3;
    step(); step();
    reset = 1'b0; in_ready = 1'b0; f_ack = 1'b0; is_last = 1'b0;
    chk_blk("reset_out", out_w, '0);
    chk_bit("reset_out_ready", out_ready, 1'b0);
    chk_bit("reset_buffer_full", buffer_full, 1'b0);
    step();
    chk_bit("idle_buffer_full", buffer_full, 1'b0);

    // Empty message: data bytes discarded, pad at byte 0, closing 0x80.
    send(32'hDEAD_BEEF, 1'b1, 2'd0);
    chk_bit("empty_pad_buffer_full", buffer_full, 1'b1);
    chk_bit("empty_pad_out_ready", out_ready, 1'b0);
    chk_w("empty_first_word", out_w[31:0], {PF, 24'h0});
    wait_ready("empty_latency", 17);
    chk_blk("empty_block", out_w, pad_only_blk);
    step(); step();
    chk_blk("empty_block_hold", out_w, pad_only_blk);
    pulse_ack();
    chk_bit("empty_done_out_ready", out_ready, 1'b0);
    chk_bit("empty_done_buffer_full", buffer_full, 1'b1);
    in_ready = 1'b1; in_w = 32'h1357_9BDF;
    step(); step(); step();
    in_ready = 1'b0;
    chk_blk("done_ignores_input", out_w, pad_only_blk);
    chk_bit("done_sticky", buffer_full, 1'b1);
    do_reset();

    // Final-word masking for byte_num 1 and 2.
    send(32'hAABB_CCDD, 1'b1, 2'd1);
    chk_w("mask_bn1", out_w[31:0], {8'hAA, PF, 16'h0});
    do_reset();
    send(32'hAABB_CCDD, 1'b1, 2'd2);
    chk_w("mask_bn2", out_w[31:0], {16'hAABB, PF, 8'h0});
    do_reset();

    // "abc"
    send(32'h6162_6300, 1'b1, 2'd3);
    wait_ready("abc_latency", 17);
    chk_w("abc_first_word", out_w[575:544], {24'h616263, PF});
    chk_w("abc_last_byte", 32'(out_w[7:0]), 32'h80);
    exp_blk = '0;
    exp_blk[575:544] = {24'h616263, PF};
    exp_blk[7:0] = 8'h80;
    chk_blk("abc_block", out_w, exp_blk);
    pulse_ack();
    do_reset();

    // 17 full words, then a 3-byte final word in slot 18 merges both pad bytes.
    exp_blk = '0;
    for (int i = 0; i < 17; i++) begin
      w = 32'hA000_0000 + 32'(i);
      send(w, 1'b0, 2'd0);
      exp_blk = {exp_blk[543:0], w};
    end
    send(32'h1122_3344, 1'b1, 2'd3);
    exp_blk = {exp_blk[543:0], 24'h112233, (PF | 8'h80)};
    chk_bit("slot18_latency", out_ready, 1'b1);
    chk_w("slot18_last_word", out_w[31:0], {24'h112233, PF | 8'h80});
    chk_blk("slot18_block", out_w, exp_blk);
    pulse_ack();
    chk_bit("slot18_done", buffer_full, 1'b1);
    do_reset();

    // 18 full words, backpressure for 5 cycles, then the empty tail becomes block 2.
    exp_blk = '0;
    for (int i = 0; i < 18; i++) begin
      w = 32'h5A00_0000 + 32'(3 * i);
      send(w, 1'b0, 2'd0);
      exp_blk = {exp_blk[543:0], w};
    end
    chk_bit("full_latency", out_ready, 1'b1);
    chk_blk("full_block1", out_w, exp_blk);
    in_w = 32'h1234_5678; is_last = 1'b1; byte_num = 2'd0; in_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_blk("full_hold_out", out_w, exp_blk);
    chk_bit("full_hold_buffer_full", buffer_full, 1'b1);
    chk_bit("full_hold_out_ready", out_ready, 1'b1);
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk_bit("ack_out_ready", out_ready, 1'b0);
    chk_bit("ack_buffer_full", buffer_full, 1'b0);
    chk_blk("ack_no_accept", out_w, exp_blk);
    step();
    in_ready = 1'b0; is_last = 1'b0;
    chk_bit("block2_accept_pad", buffer_full, 1'b1);
    chk_w("block2_first_word", out_w[31:0], {PF, 24'h0});
    wait_ready("block2_latency", 17);
    chk_blk("block2", out_w, pad_only_blk);
    pulse_ack();
    chk_bit("block2_done_buffer_full", buffer_full, 1'b1);
    chk_bit("block2_done_out_ready", out_ready, 1'b0);
    step();
    chk_bit("block2_done_sticky", buffer_full, 1'b1);
    do_reset();

    // Reset while padding discards everything; a fresh message then works.
    for (int i = 0; i < 4; i++) send(32'hC0DE_0000 + 32'(i), 1'b0, 2'd0);
    send(32'hC0DE_0004, 1'b1, 2'd2);
    step(); step();
    chk_bit("mid_pad_state", buffer_full, 1'b1);
    reset = 1'b1; in_ready = 1'b1; f_ack = 1'b1;
    step();
    reset = 1'b0; in_ready = 1'b0; f_ack = 1'b0;
    chk_blk("pad_reset_out", out_w, '0);
    chk_bit("pad_reset_out_ready", out_ready, 1'b0);
    chk_bit("pad_reset_buffer_full", buffer_full, 1'b0);
    send(32'h6162_6300, 1'b1, 2'd3);
    wait_ready("post_reset_latency", 17);
    exp_blk = '0;
    exp_blk[575:544] = {24'h616263, PF};
    exp_blk[7:0] = 8'h80;
    chk_blk("post_reset_block", out_w, exp_blk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
